ysyx_23060075_axi_arbiter: RTL and testbench
============================================

YSYX_23060075_AXI_ARBITER -- requirements
Module: ysyx_23060075_axi_arbiter

Interface
REQ-001 SHALL have parameter ROUND_ROBIN, default 1, where 1 gives round-robin arbitration and 0 gives fixed priority with master 0 highest.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports m<i>_araddr/arvalid (in, 32/1) and m<i>_arready (out, 1) for i=0,1: read address channel of master i.
REQ-005 SHALL have ports m<i>_rdata (out, 32), m<i>_rresp (out, 2), m<i>_rvalid (out, 1) and m<i>_rready (in, 1): read data channel.
REQ-006 SHALL have ports m<i>_awaddr/awvalid (in, 32/1) and m<i>_awready (out, 1): write address channel.
REQ-007 SHALL have ports m<i>_wdata/wstrb/wvalid (in, 32/4/1) and m<i>_wready (out, 1): write data channel.
REQ-008 SHALL have ports m<i>_bresp (out, 2), m<i>_bvalid (out, 1) and m<i>_bready (in, 1): write response channel.
REQ-009 SHALL have ports s_ar*, s_r*, s_aw*, s_w* and s_b*, each the mirror of the master channels with directions reversed: the single shared slave (sram).
REQ-010 SHALL have port grant  out  2  one-hot owner of the slave; 2'b00 when idle.

Function
REQ-011 SHALL implement an FSM with states IDLE, RADDR, RDATA, WADDR, WRESP, allowing one outstanding transaction in total.
REQ-012 In IDLE, a master SHALL be requesting if arvalid=1 (read request) or awvalid=1 (write request); wvalid is not required to request.
REQ-013 If a requesting master has both arvalid and awvalid high, the read SHALL be served first.
REQ-014 If both masters request, the winner SHALL be the master not granted last (ROUND_ROBIN=1) or master 0 (ROUND_ROBIN=0).
REQ-015 The last-granted pointer SHALL update only when a grant is issued.
REQ-016 The grant SHALL be registered: a request sampled in IDLE at edge N gives grant and state RADDR/WADDR after edge N, and the slave sees valid in cycle N+1.
REQ-017 In RADDR: s_ar* = granted m_ar*; m_arready = s_arready; on s_arvalid&s_arready, go to RDATA.
REQ-018 In RDATA: s_rready = granted m_rready; m_rdata/rresp/rvalid = s_r*; on s_rvalid&s_rready, go to IDLE.
REQ-019 In WADDR, AW and W SHALL be forwarded independently, with aw_done/w_done flags set on each handshake and that channel's valid dropped once its flag is set.
REQ-020 WADDR SHALL go to WRESP once both flags are set, including the case where both handshake in the same cycle; the flags clear on entry to WRESP.
REQ-021 In WRESP: s_bready = granted m_bready; m_b* = s_b*; on s_bvalid&s_bready, go to IDLE.
REQ-022 rresp/bresp SHALL pass through unmodified, including error codes; no retry.
REQ-023 Leaving RDATA/WRESP SHALL always pass through IDLE for one cycle, so back-to-back grants have a 1-cycle bubble.
REQ-024 A non-granted master SHALL see all its ready and valid outputs at 0; its rdata and bresp outputs are 0.
REQ-025 Outside a matching state, every s_* valid/ready output SHALL be 0; data and address outputs are don't-care, driven 0.
REQ-026 A master that drops its valid before the handshake SHALL cause no error: the arbiter waits in the current state and does not re-arbitrate.
REQ-027 grant SHALL be 2'b00 in IDLE and the one-hot owner in all other states.

Reset
REQ-028 On rst=1 (asynchronous), the arbiter SHALL go to state IDLE, set grant=0, clear aw_done/w_done, and set the pointer so master 0 wins the first tie.
REQ-029 During reset, all valid/ready outputs on every port SHALL be 0.
REQ-030 Reset asserted mid-transaction SHALL abandon that transaction without completing it; after release, arbitration restarts from IDLE.

Verification
REQ-031 m0 read only, araddr=0x80000000, sram returns 0x00000413 -> grant=01 one cycle after request, m0_rdata=0x00000413, rresp=0, grant=00 after the R handshake.
REQ-032 m0 read and m1 write (0x80001000, 0xDEADBEEF, strb 4'b1111) asserted in the same cycle, ROUND_ROBIN=1 -> m0 served first, then m1 after a 1-cycle IDLE; a read of 0x80001000 returns 0xDEADBEEF.
REQ-033 Both masters issue continuous reads for 8 transactions, ROUND_ROBIN=1 -> grants alternate 01,10,01,...; each master completes 4 reads.
REQ-034 m1 write with wvalid two cycles before awvalid, and the slave giving awready 3 cycles late -> exactly one AW and one W handshake, then WRESP, then bvalid routed only to m1.
REQ-035 rst pulse while in RDATA with s_rvalid=0 -> all outputs 0 immediately; after release, a new m1 read is granted and completes normally.
REQ-036 Slave returns rresp=2'b10 -> m0_rresp=2'b10; the FSM returns to IDLE with no retry.

Source files
------------

// File: rtl/ysyx_23060075_axi_arbiter.sv
// Two-master to one-slave AXI-Lite arbiter with a single outstanding transaction.
// Round-robin or fixed-priority grant; the grant is registered and held until the response completes.
module ysyx_23060075_axi_arbiter #(
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] m0_araddr,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  output logic [31:0] m0_rdata,
  output logic [1:0]  m0_rresp,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  input  logic [31:0] m0_awaddr,
  input  logic        m0_awvalid,
  output logic        m0_awready,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  input  logic        m0_wvalid,
  output logic        m0_wready,
  output logic [1:0]  m0_bresp,
  output logic        m0_bvalid,
  input  logic        m0_bready,

  input  logic [31:0] m1_araddr,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  output logic [31:0] m1_rdata,
  output logic [1:0]  m1_rresp,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  input  logic [31:0] m1_awaddr,
  input  logic        m1_awvalid,
  output logic        m1_awready,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  input  logic        m1_wvalid,
  output logic        m1_wready,
  output logic [1:0]  m1_bresp,
  output logic        m1_bvalid,
  input  logic        m1_bready,

  output logic [31:0] s_araddr,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [31:0] s_rdata,
  input  logic [1:0]  s_rresp,
  input  logic        s_rvalid,
  output logic        s_rready,
  output logic [31:0] s_awaddr,
  output logic        s_awvalid,
  input  logic        s_awready,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  output logic        s_wvalid,
  input  logic        s_wready,
  input  logic [1:0]  s_bresp,
  input  logic        s_bvalid,
  output logic        s_bready,

  output logic [1:0]  grant
);

  typedef enum logic [2:0] {StIdle, StRaddr, StRdata, StWaddr, StWresp} state_e;

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;

  logic        sel;
  logic [31:0] g_araddr, g_awaddr, g_wdata;
  logic [3:0]  g_wstrb;
  logic        g_arvalid, g_rready, g_awvalid, g_wvalid, g_bready;
  logic        req0, req1, win, win_rd;
  logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;

  assign sel       = grant_q[1];
  assign g_araddr  = sel ? m1_araddr  : m0_araddr;
  assign g_arvalid = sel ? m1_arvalid : m0_arvalid;
  assign g_rready  = sel ? m1_rready  : m0_rready;
  assign g_awaddr  = sel ? m1_awaddr  : m0_awaddr;
  assign g_awvalid = sel ? m1_awvalid : m0_awvalid;
  assign g_wdata   = sel ? m1_wdata   : m0_wdata;
  assign g_wstrb   = sel ? m1_wstrb   : m0_wstrb;
  assign g_wvalid  = sel ? m1_wvalid  : m0_wvalid;
  assign g_bready  = sel ? m1_bready  : m0_bready;

  // wvalid alone does not request; a master with both AR and AW pending goes to the read first.
  assign req0   = m0_arvalid | m0_awvalid;
  assign req1   = m1_arvalid | m1_awvalid;
  assign win    = (req0 & req1) ? ((ROUND_ROBIN != 0) ? ~last_q : 1'b0) : req1;
  assign win_rd = win ? m1_arvalid : m0_arvalid;

  assign ar_hs = (state_q == StRaddr) & g_arvalid & s_arready;
  assign r_hs  = (state_q == StRdata) & s_rvalid & g_rready;
  assign aw_hs = (state_q == StWaddr) & g_awvalid & ~aw_done_q & s_awready;
  assign w_hs  = (state_q == StWaddr) & g_wvalid & ~w_done_q & s_wready;
  assign b_hs  = (state_q == StWresp) & s_bvalid & g_bready;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      StIdle: begin
        if (req0 | req1) begin
          grant_d = win ? 2'b10 : 2'b01;
          last_d  = win;
          state_d = win_rd ? StRaddr : StWaddr;
        end
      end
      StRaddr: begin
        if (ar_hs) state_d = StRdata;
      end
      StRdata: begin
        if (r_hs) begin
          state_d = StIdle;
          grant_d = 2'b00;
        end
      end
      StWaddr: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d   = StWresp;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      StWresp: begin
        if (b_hs) begin
          state_d = StIdle;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = 2'b00;
      end
    endcase
  end

  // Pointer resets to master 1 so that master 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    s_araddr   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awaddr   = '0;
    s_awvalid  = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    m0_arready = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rvalid  = 1'b0;
    m0_awready = 1'b0;
    m0_wready  = 1'b0;
    m0_bresp   = '0;
    m0_bvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bresp   = '0;
    m1_bvalid  = 1'b0;
    unique case (state_q)
      StRaddr: begin
        s_araddr  = g_araddr;
        s_arvalid = g_arvalid;
        if (sel) m1_arready = s_arready;
        else     m0_arready = s_arready;
      end
      StRdata: begin
        s_rready = g_rready;
        if (sel) begin
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
          m1_rvalid = s_rvalid;
        end else begin
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
          m0_rvalid = s_rvalid;
        end
      end
      StWaddr: begin
        // Each channel goes quiet once its own handshake has been taken.
        s_awaddr  = g_awaddr;
        s_awvalid = g_awvalid & ~aw_done_q;
        s_wdata   = g_wdata;
        s_wstrb   = g_wstrb;
        s_wvalid  = g_wvalid & ~w_done_q;
        if (sel) begin
          m1_awready = s_awready & ~aw_done_q;
          m1_wready  = s_wready & ~w_done_q;
        end else begin
          m0_awready = s_awready & ~aw_done_q;
          m0_wready  = s_wready & ~w_done_q;
        end
      end
      StWresp: begin
        s_bready = g_bready;
        if (sel) begin
          m1_bresp  = s_bresp;
          m1_bvalid = s_bvalid;
        end else begin
          m0_bresp  = s_bresp;
          m0_bvalid = s_bvalid;
        end
      end
      default: ;
    endcase
  end

  assign grant = grant_q;

endmodule

// File: tb/tb_ysyx_23060075_axi_arbiter.sv
// Directed bench for the two-master AXI-Lite arbiter with a behavioural SRAM slave.
module tb_ysyx_23060075_axi_arbiter;

  localparam int Bound = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] m0_araddr, m0_rdata, m0_awaddr, m0_wdata;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_awvalid, m0_awready;
  logic        m0_wvalid, m0_wready, m0_bvalid, m0_bready;
  logic [1:0]  m0_rresp, m0_bresp;
  logic [3:0]  m0_wstrb;
  logic [31:0] m1_araddr, m1_rdata, m1_awaddr, m1_wdata;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_awvalid, m1_awready;
  logic        m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic [1:0]  m1_rresp, m1_bresp;
  logic [3:0]  m1_wstrb;
  logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
  logic        s_wvalid, s_wready, s_bvalid, s_bready;
  logic [1:0]  s_rresp, s_bresp;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;

  ysyx_23060075_axi_arbiter #(.ROUND_ROBIN(1)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
    .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .grant(grant)
  );

  // Behavioural SRAM slave with configurable read latency, AW stall and read response code.
  logic [31:0] mem [0:4095];
  int          r_delay = 0;
  int          aw_delay = 0;
  logic [1:0]  rresp_cfg = 2'b00;
  int          aw_cnt = 0;
  int          r_cnt;
  logic        r_busy, aw_got, w_got;
  logic [31:0] r_addr, aw_a, w_d;
  logic [3:0]  w_s;
  int          ar_hs_n = 0, aw_hs_n = 0, w_hs_n = 0;

  assign s_arready = 1'b1;
  assign s_wready  = 1'b1;
  assign s_awready = s_awvalid && (aw_cnt >= aw_delay);

  always @(posedge clk) begin
    if (s_awvalid && !s_awready) aw_cnt <= aw_cnt + 1;
    else                         aw_cnt <= 0;
    if (s_arvalid && s_arready) ar_hs_n <= ar_hs_n + 1;
    if (s_awvalid && s_awready) aw_hs_n <= aw_hs_n + 1;
    if (s_wvalid && s_wready)   w_hs_n  <= w_hs_n + 1;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_rvalid <= 1'b0; s_rdata <= '0; s_rresp <= '0;
      r_busy <= 1'b0; r_cnt <= 0; r_addr <= '0;
      s_bvalid <= 1'b0; s_bresp <= '0;
      aw_got <= 1'b0; w_got <= 1'b0; aw_a <= '0; w_d <= '0; w_s <= '0;
      mem[0] <= 32'h0000_0413;
    end else begin
      if (s_arvalid && s_arready) begin
        r_busy <= 1'b1; r_cnt <= r_delay; r_addr <= s_araddr;
      end else if (r_busy && !s_rvalid) begin
        if (r_cnt == 0) begin
          s_rvalid <= 1'b1; s_rdata <= mem[r_addr[13:2]]; s_rresp <= rresp_cfg;
        end else begin
          r_cnt <= r_cnt - 1;
        end
      end else if (s_rvalid && s_rready) begin
        s_rvalid <= 1'b0; r_busy <= 1'b0;
      end
      if (s_awvalid && s_awready) begin aw_got <= 1'b1; aw_a <= s_awaddr; end
      if (s_wvalid && s_wready) begin w_got <= 1'b1; w_d <= s_wdata; w_s <= s_wstrb; end
      if (aw_got && w_got && !s_bvalid) begin
        for (int b = 0; b < 4; b++)
          if (w_s[b]) mem[aw_a[13:2]][8*b +: 8] <= w_d[8*b +: 8];
        s_bvalid <= 1'b1; s_bresp <= 2'b00; aw_got <= 1'b0; w_got <= 1'b0;
      end else if (s_bvalid && s_bready) begin
        s_bvalid <= 1'b0;
      end
    end
  end

  // Grant log, idle-gap timing and a watch on outputs of the non-granted master.
  int         cyc = 0;
  logic [1:0] prev_grant = 2'b00;
  logic [1:0] glog[$];
  int         rise_q[$];
  int         fall_q[$];
  int         bad = 0;
  logic       any_vr;

  assign any_vr = m0_arready | m0_rvalid | m0_awready | m0_wready | m0_bvalid |
                  m1_arready | m1_rvalid | m1_awready | m1_wready | m1_bvalid |
                  s_arvalid | s_rready | s_awvalid | s_wvalid | s_bready;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (grant != 2'b00 && prev_grant == 2'b00) begin
      glog.push_back(grant);
      rise_q.push_back(cyc);
    end
    if (grant == 2'b00 && prev_grant != 2'b00) fall_q.push_back(cyc);
    prev_grant <= grant;
    if (!grant[0] && (m0_arready || m0_rvalid || m0_awready || m0_wready || m0_bvalid ||
                      m0_rdata !== 32'h0 || m0_bresp !== 2'b00))
      bad <= bad + 1;
    if (!grant[1] && (m1_arready || m1_rvalid || m1_awready || m1_wready || m1_bvalid ||
                      m1_rdata !== 32'h0 || m1_bresp !== 2'b00))
      bad <= bad + 1;
  end

  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ar(input int m, input logic [31:0] a, input logic v);
    if (m == 0) begin m0_araddr = a; m0_arvalid = v; end
    else        begin m1_araddr = a; m1_arvalid = v; end
  endtask

  task automatic set_rready(input int m, input logic v);
    if (m == 0) m0_rready = v; else m1_rready = v;
  endtask

  task automatic set_aw(input int m, input logic [31:0] a, input logic v);
    if (m == 0) begin m0_awaddr = a; m0_awvalid = v; end
    else        begin m1_awaddr = a; m1_awvalid = v; end
  endtask

  task automatic set_w(input int m, input logic [31:0] d, input logic [3:0] s, input logic v);
    if (m == 0) begin m0_wdata = d; m0_wstrb = s; m0_wvalid = v; end
    else        begin m1_wdata = d; m1_wstrb = s; m1_wvalid = v; end
  endtask

  task automatic set_bready(input int m, input logic v);
    if (m == 0) m0_bready = v; else m1_bready = v;
  endtask

  task automatic do_read(input int m, input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] r, output bit ok);
    int n;
    bit hs;
    ok = 1'b0; d = '0; r = '0; hs = 1'b0; n = 0;
    set_ar(m, a, 1'b1);
    set_rready(m, 1'b1);
    while (!hs && n < Bound) begin
      @(negedge clk);
      hs = (m == 0) ? m0_arready : m1_arready;
      @(posedge clk); #1;
      n++;
    end
    set_ar(m, a, 1'b0);
    if (!hs) begin
      set_rready(m, 1'b0);
      return;
    end
    hs = 1'b0; n = 0;
    while (!hs && n < Bound) begin
      @(negedge clk);
      hs = (m == 0) ? m0_rvalid : m1_rvalid;
      if (hs) begin
        d = (m == 0) ? m0_rdata : m1_rdata;
        r = (m == 0) ? m0_rresp : m1_rresp;
      end
      @(posedge clk); #1;
      n++;
    end
    set_rready(m, 1'b0);
    ok = hs;
  endtask

  task automatic do_write(input int m, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int w_lead, output logic [1:0] b,
                          output bit ok);
    int n;
    bit aw_now, w_now, aw_dn, w_dn, hs;
    ok = 1'b0; b = '0; aw_dn = 1'b0; w_dn = 1'b0; n = 0;
    set_w(m, d, s, 1'b1);
    set_bready(m, 1'b1);
    repeat (w_lead) begin @(posedge clk); #1; end
    set_aw(m, a, 1'b1);
    while (!(aw_dn && w_dn) && n < Bound) begin
      @(negedge clk);
      aw_now = (m == 0) ? m0_awready : m1_awready;
      w_now  = (m == 0) ? m0_wready : m1_wready;
      @(posedge clk); #1;
      n++;
      if (aw_now) begin aw_dn = 1'b1; set_aw(m, a, 1'b0); end
      if (w_now)  begin w_dn = 1'b1; set_w(m, d, s, 1'b0); end
    end
    if (!(aw_dn && w_dn)) begin
      set_aw(m, a, 1'b0); set_w(m, d, s, 1'b0); set_bready(m, 1'b0);
      return;
    end
    hs = 1'b0; n = 0;
    while (!hs && n < Bound) begin
      @(negedge clk);
      hs = (m == 0) ? m0_bvalid : m1_bvalid;
      if (hs) b = (m == 0) ? m0_bresp : m1_bresp;
      @(posedge clk); #1;
      n++;
    end
    set_bready(m, 1'b0);
    ok = hs;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d0, da, db;
    logic [1:0]  r0, ra, rb, b1, expg;
    bit          ok0, ok1, oka, okb;
    int          base, fbase, c0, n0, n1, ar0, aw0, w00;

    rst = 1'b1;
    m0_araddr = '0; m0_arvalid = 0; m0_rready = 0; m0_awaddr = '0; m0_awvalid = 0;
    m0_wdata = '0; m0_wstrb = '0; m0_wvalid = 0; m0_bready = 0;
    m1_araddr = '0; m1_arvalid = 0; m1_rready = 0; m1_awaddr = '0; m1_awvalid = 0;
    m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 0; m1_bready = 0;
    repeat (2) @(negedge clk);
    check("reset_grant", {30'b0, grant}, 32'h0);
    check("reset_quiet", {31'b0, any_vr}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Simultaneous m0 read and m1 write straight after reset: m0 wins the first tie.
    base = glog.size(); fbase = fall_q.size();
    fork
      do_read(0, 32'h8000_0000, d0, r0, ok0);
      do_write(1, 32'h8000_1000, 32'hDEAD_BEEF, 4'b1111, 0, b1, ok1);
    join
    check("tie_read_ok", {31'b0, ok0}, 32'h1);
    check("tie_read_data", d0, 32'h0000_0413);
    check("tie_write_ok", {31'b0, ok1}, 32'h1);
    check("tie_write_bresp", {30'b0, b1}, 32'h0);
    check("tie_first_grant", {30'b0, glog[base]}, 32'h1);
    check("tie_second_grant", {30'b0, glog[base+1]}, 32'h2);
    check("tie_idle_bubble", rise_q[base+1] - fall_q[fbase], 32'd1);
    do_read(0, 32'h8000_1000, d0, r0, ok0);
    check("readback_ok", {31'b0, ok0}, 32'h1);
    check("readback_data", d0, 32'hDEAD_BEEF);

    // Lone m0 read: grant one cycle after the request, released after R handshake.
    base = glog.size(); c0 = cyc;
    do_read(0, 32'h8000_0000, d0, r0, ok0);
    check("rd_grant_owner", {30'b0, glog[base]}, 32'h1);
    check("rd_grant_latency", rise_q[base] - c0, 32'd1);
    check("rd_data", d0, 32'h0000_0413);
    check("rd_rresp", {30'b0, r0}, 32'h0);
    check("rd_grant_release", {30'b0, grant}, 32'h0);

    // m1 write with W leading AW by two cycles and AW stalled three cycles by the slave.
    aw_delay = 3; aw0 = aw_hs_n; w00 = w_hs_n;
    do_write(1, 32'h8000_2000, 32'hCAFE_F00D, 4'b1111, 2, b1, ok1);
    aw_delay = 0;
    check("lateaw_ok", {31'b0, ok1}, 32'h1);
    check("lateaw_bresp", {30'b0, b1}, 32'h0);
    check("lateaw_aw_count", aw_hs_n - aw0, 32'd1);
    check("lateaw_w_count", w_hs_n - w00, 32'd1);
    do_read(1, 32'h8000_2000, d0, r0, ok0);
    check("lateaw_readback", d0, 32'hCAFE_F00D);

    // Continuous reads from both masters alternate under round robin.
    base = glog.size(); n0 = 0; n1 = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          do_read(0, 32'h8000_0000, da, ra, oka);
          if (oka && da == 32'h0000_0413) n0++;
        end
      end
      begin
        for (int j = 0; j < 4; j++) begin
          do_read(1, 32'h8000_0000, db, rb, okb);
          if (okb && db == 32'h0000_0413) n1++;
        end
      end
    join
    check("rr_m0_reads", n0, 32'd4);
    check("rr_m1_reads", n1, 32'd4);
    for (int k = 0; k < 8; k++) begin
      expg = (k % 2 == 0) ? 2'b01 : 2'b10;
      check($sformatf("rr_grant_%0d", k), {30'b0, glog[base+k]}, {30'b0, expg});
    end

    // Error response passes through and is not retried.
    rresp_cfg = 2'b10; ar0 = ar_hs_n;
    do_read(0, 32'h8000_0000, d0, r0, ok0);
    rresp_cfg = 2'b00;
    check("err_ok", {31'b0, ok0}, 32'h1);
    check("err_rresp", {30'b0, r0}, 32'h2);
    repeat (3) begin @(posedge clk); #1; end
    check("err_idle", {30'b0, grant}, 32'h0);
    check("err_no_retry", ar_hs_n - ar0, 32'd1);

    // Reset while waiting in RDATA, then a fresh m1 read.
    r_delay = 20;
    set_ar(0, 32'h8000_0000, 1'b1);
    set_rready(0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    set_ar(0, 32'h8000_0000, 1'b0);
    check("mid_grant", {30'b0, grant}, 32'h1);
    check("mid_rready_fwd", {31'b0, s_rready}, 32'h1);
    check("mid_no_rvalid", {31'b0, m0_rvalid}, 32'h0);
    rst = 1'b1;
    #1;
    check("rst_async_grant", {30'b0, grant}, 32'h0);
    check("rst_async_quiet", {31'b0, any_vr}, 32'h0);
    @(negedge clk);
    rst = 1'b0; r_delay = 0;
    set_rready(0, 1'b0);
    @(posedge clk); #1;
    base = glog.size();
    do_read(1, 32'h8000_0000, d0, r0, ok0);
    check("post_rst_ok", {31'b0, ok0}, 32'h1);
    check("post_rst_data", d0, 32'h0000_0413);
    check("post_rst_owner", {30'b0, glog[base]}, 32'h2);

    check("nongranted_quiet", bad, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
